// File: rtl/draw_level_text.sv
// Overlays a 16x16-character level-text window (8x16 px glyphs) on the VGA stream.
// Two-stage pipeline: stage 1 registers timing and hit info, stage 2 paints from the font row.
module draw_level_text #(
  parameter logic [10:0] XPOS  = 11'd448,
  parameter logic [10:0] YPOS  = 11'd20,
  parameter logic [11:0] COLOR = 12'hff0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        enable,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line
);

  // 12-bit window ends so the comparisons never wrap.
  localparam logic [11:0] XEnd = {1'b0, XPOS} + 12'd128;
  localparam logic [11:0] YEnd = {1'b0, YPOS} + 12'd256;

  logic        in_win;
  logic [10:0] dx, dy;

  always_comb begin
    in_win = (hcount_in >= XPOS) && ({1'b0, hcount_in} < XEnd) &&
             (vcount_in >= YPOS) && ({1'b0, vcount_in} < YEnd);
    dx = hcount_in - XPOS;
    dy = vcount_in - YPOS;
    if (in_win) begin
      char_xy   = {dy[7:4], dx[6:3]};
      char_line = dy[3:0];
    end else begin
      char_xy   = 8'h00;
      char_line = 4'h0;
    end
  end

  logic [10:0] hcount1_q, vcount1_q;
  logic        hsync1_q, hblnk1_q, vsync1_q, vblnk1_q;
  logic [11:0] rgb1_q;
  logic        hit1_q;
  logic [2:0]  xoff1_q;
  logic [11:0] rgb_d;

  // char_pixels arrives during the stage-1 cycle, aligned with xoff1_q.
  always_comb begin
    rgb_d = rgb1_q;
    if (hblnk1_q || vblnk1_q) begin
      rgb_d = 12'h000;
    end else if (hit1_q && char_pixels[3'd7 - xoff1_q]) begin
      rgb_d = COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount1_q  <= '0;
      hsync1_q   <= 1'b0;
      hblnk1_q   <= 1'b0;
      vcount1_q  <= '0;
      vsync1_q   <= 1'b0;
      vblnk1_q   <= 1'b0;
      rgb1_q     <= '0;
      hit1_q     <= 1'b0;
      xoff1_q    <= '0;
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount1_q  <= hcount_in;
      hsync1_q   <= hsync_in;
      hblnk1_q   <= hblnk_in;
      vcount1_q  <= vcount_in;
      vsync1_q   <= vsync_in;
      vblnk1_q   <= vblnk_in;
      rgb1_q     <= rgb_in;
      hit1_q     <= in_win && enable;
      xoff1_q    <= dx[2:0];
      hcount_out <= hcount1_q;
      hsync_out  <= hsync1_q;
      hblnk_out  <= hblnk1_q;
      vcount_out <= vcount1_q;
      vsync_out  <= vsync1_q;
      vblnk_out  <= vblnk1_q;
      rgb_out    <= rgb_d;
    end
  end

endmodule

// File: tb/tb_draw_level_text.sv
// Directed self-checking bench for draw_level_text with default window parameters.
module tb_draw_level_text;

  localparam logic [11:0] Col = 12'hff0;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        enable;
  logic [7:0]  char_pixels;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [7:0]  char_xy;
  logic [3:0]  char_line;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  draw_level_text dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .enable(enable), .char_pixels(char_pixels),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .char_xy(char_xy), .char_line(char_line)
  );

  // Presents one pixel, returns its addresses and, two edges later, its colour.
  task automatic pixel(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                       input logic en, input logic hb, input logic vb, input logic [7:0] cp,
                       output logic [7:0] xy, output logic [3:0] ln, output logic [11:0] ro);
    @(negedge clk);
    hcount_in = h; vcount_in = v; rgb_in = rgb; enable = en;
    hblnk_in = hb; vblnk_in = vb; hsync_in = 1'b0; vsync_in = 1'b0;
    #1;
    xy = char_xy; ln = char_line;
    @(negedge clk);
    char_pixels = cp;
    @(negedge clk);
    ro = rgb_out;
  endtask

  task automatic test_reset();
    logic [38:0] outs;
    @(negedge clk);
    rst = 1'b0; hcount_in = 11'd333; vcount_in = 11'd44; hsync_in = 1'b1; hblnk_in = 1'b0;
    vsync_in = 1'b1; vblnk_in = 1'b0; rgb_in = 12'h5a5; enable = 1'b1; char_pixels = 8'hff;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    outs = {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out};
    n_total++;
    if (outs !== 39'd0) $display("FAIL reset_outputs: got %h want 0", outs);
    else n_pass++;
    rst = 1'b0; hcount_in = 11'd10; vcount_in = 11'd10; hsync_in = 1'b0; vsync_in = 1'b0;
    @(negedge clk);
    n_total++;
    if (hcount_out !== 11'd0) $display("FAIL reset_latency1: hcount_out %0d want 0", hcount_out);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (hcount_out !== 11'd10 || vcount_out !== 11'd10)
      $display("FAIL reset_latency2: h %0d v %0d want 10 10", hcount_out, vcount_out);
    else n_pass++;
  endtask

  task automatic test_origin();
    logic [7:0] xy; logic [3:0] ln; logic [11:0] ro;
    pixel(11'd448, 11'd20, 12'habc, 1'b1, 1'b0, 1'b0, 8'h80, xy, ln, ro);
    n_total++;
    if (xy !== 8'h00 || ln !== 4'h0) $display("FAIL origin_addr: xy %h ln %h want 00 0", xy, ln);
    else n_pass++;
    n_total++;
    if (ro !== Col) $display("FAIL origin_rgb: got %h want %h", ro, Col);
    else n_pass++;
    pixel(11'd449, 11'd20, 12'habc, 1'b1, 1'b0, 1'b0, 8'h80, xy, ln, ro);
    n_total++;
    if (ro !== 12'habc) $display("FAIL origin_next: got %h want abc", ro);
    else n_pass++;
  endtask

  task automatic test_addressing();
    logic [7:0] xy; logic [3:0] ln; logic [11:0] ro;
    pixel(11'd509, 11'd77, 12'h321, 1'b1, 1'b0, 1'b0, 8'h04, xy, ln, ro);
    n_total++;
    if (xy !== 8'h37 || ln !== 4'h9) $display("FAIL addr_xy: xy %h ln %h want 37 9", xy, ln);
    else n_pass++;
    n_total++;
    if (ro !== Col) $display("FAIL addr_bit2: got %h want %h", ro, Col);
    else n_pass++;
    pixel(11'd509, 11'd77, 12'h321, 1'b1, 1'b0, 1'b0, 8'h08, xy, ln, ro);
    n_total++;
    if (ro !== 12'h321) $display("FAIL addr_bit3: got %h want 321", ro);
    else n_pass++;
  endtask

  task automatic test_boundaries();
    logic [7:0] xy; logic [3:0] ln; logic [11:0] ro;
    logic [10:0] hs[6] = '{11'd575, 11'd576, 11'd447, 11'd448, 11'd448, 11'd448};
    logic [10:0] vs[6] = '{11'd30, 11'd30, 11'd30, 11'd275, 11'd276, 11'd19};
    logic [11:0] ex[6] = '{Col, 12'h123, 12'h123, Col, 12'h123, 12'h123};
    logic [7:0]  ea[6] = '{8'h0f, 8'h00, 8'h00, 8'hf0, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++) begin
      pixel(hs[i], vs[i], 12'h123, 1'b1, 1'b0, 1'b0, 8'hff, xy, ln, ro);
      n_total++;
      if (ro !== ex[i] || xy !== ea[i])
        $display("FAIL boundary_%0d: h %0d v %0d rgb %h xy %h want %h %h",
                 i, hs[i], vs[i], ro, xy, ex[i], ea[i]);
      else n_pass++;
    end
  endtask

  task automatic test_blank_enable();
    logic [7:0] xy; logic [3:0] ln; logic [11:0] ro;
    pixel(11'd460, 11'd40, 12'h456, 1'b1, 1'b1, 1'b0, 8'hff, xy, ln, ro);
    n_total++;
    if (ro !== 12'h000) $display("FAIL hblank: got %h want 000", ro);
    else n_pass++;
    pixel(11'd460, 11'd40, 12'h456, 1'b1, 1'b0, 1'b1, 8'hff, xy, ln, ro);
    n_total++;
    if (ro !== 12'h000) $display("FAIL vblank: got %h want 000", ro);
    else n_pass++;
    pixel(11'd460, 11'd40, 12'h456, 1'b0, 1'b0, 1'b0, 8'hff, xy, ln, ro);
    n_total++;
    if (ro !== 12'h456) $display("FAIL enable_off: got %h want 456", ro);
    else n_pass++;
  endtask

  // Streams a line with sync/blank/enable activity and a one-cycle reset at hcount 500.
  task automatic test_back_to_back();
    localparam int N = 161;
    localparam logic [7:0] Pat = 8'b1010_0101;
    logic [10:0] hq[N];
    logic [11:0] rq[N];
    logic        eq[N], hbq[N], hsq[N], vsq[N];
    int          r;
    logic [11:0] exp_rgb;
    logic [25:0] exp_t, got_t;
    logic [10:0] dx;
    r = 500 - 440;
    char_pixels = Pat;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        int j;
        j = i - 2;
        if (i == r + 1 || i == r + 2) begin
          exp_rgb = 12'h000;
          exp_t   = 26'd0;
        end else begin
          dx = hq[j] - 11'd448;
          exp_t = {hq[j], hsq[j], hbq[j], 11'd100, vsq[j], 1'b0};
          if (hbq[j]) exp_rgb = 12'h000;
          else if (hq[j] >= 11'd448 && hq[j] < 11'd576 && eq[j] && Pat[7 - int'(dx[2:0])])
            exp_rgb = Col;
          else exp_rgb = rq[j];
        end
        got_t = {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out};
        if (i != r + 1 && i != r + 2 && !(i >= 2 && i - 2 >= 0)) exp_t = got_t;
        n_total++;
        if (rgb_out !== exp_rgb || got_t !== exp_t)
          $display("FAIL stream_h%0d: rgb %h timing %h want %h %h",
                   440 + i - 2, rgb_out, got_t, exp_rgb, exp_t);
        else n_pass++;
      end
      hq[i]  = 11'(440 + i);
      rq[i]  = 12'(12'h800 + i * 3);
      eq[i]  = !(hq[i] >= 11'd460 && hq[i] < 11'd468);
      hbq[i] = hq[i] >= 11'd590;
      hsq[i] = hq[i] >= 11'd592 && hq[i] < 11'd596;
      vsq[i] = hq[i][0];
      hcount_in = hq[i]; vcount_in = 11'd100; rgb_in = rq[i]; enable = eq[i];
      hblnk_in = hbq[i]; hsync_in = hsq[i]; vsync_in = vsq[i]; vblnk_in = 1'b0;
      rst = (i == r);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; hblnk_in = 1'b0;
    vsync_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0; enable = 1'b0; char_pixels = '0;
    test_reset();
    test_origin();
    test_addressing();
    test_boundaries();
    test_blank_enable();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/draw_level_text.md
Name: draw_level_text

Overview:
- Video pipeline stage that overlays a 16x16-character text window (8x16-pixel glyphs, 128x256 px) on the incoming VGA stream.
- Each pixel's screen position becomes a character address (char_xy), which drives the 16x16 level-text character ROM, and a glyph row (char_line).
- The char ROM output plus char_line address the external font ROM; the returned glyph row (char_pixels) is used to paint the pixel.
- Sits between the background/sprite draw stages and the VGA output stage; all timing signals are delayed to match its 2-cycle latency.

Parameters:
XPOS, 448, left edge of text window in pixels (11-bit)
YPOS, 20, top edge of text window in lines (11-bit)
COLOR, 12'hf_f_0, RGB444 colour of lit glyph pixels

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
hcount_in  in  11  horizontal pixel counter
hsync_in  in  1  horizontal sync
hblnk_in  in  1  horizontal blank
vcount_in  in  11  vertical line counter
vsync_in  in  1  vertical sync
vblnk_in  in  1  vertical blank
rgb_in  in  12  upstream pixel colour
enable  in  1  1 = draw text, 0 = pass-through
char_pixels  in  8  font ROM glyph row; MSB = leftmost pixel; valid 1 cycle after char_xy/char_line
hcount_out  out  11  hcount_in delayed 2 cycles
hsync_out  out  1  delayed 2 cycles
hblnk_out  out  1  delayed 2 cycles
vcount_out  out  11  delayed 2 cycles
vsync_out  out  1  delayed 2 cycles
vblnk_out  out  1  delayed 2 cycles
rgb_out  out  12  output pixel colour
char_xy  out  8  {row[3:0], col[3:0]} to char ROM
char_line  out  4  glyph row to font ROM

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Window test (combinational on inputs):
  - in_win = (hcount_in >= XPOS) && (hcount_in < XPOS+128) && (vcount_in >= YPOS) && (vcount_in < YPOS+256).
  - Offsets: dx = hcount_in - XPOS and dy = vcount_in - YPOS, 11-bit unsigned.
- Address outputs (combinational, same cycle as inputs):
  - When in_win: char_xy = {dy[7:4], dx[6:3]} and char_line = dy[3:0].
  - Otherwise: char_xy = 8'h00 and char_line = 4'h0.
- Stage 1 (registered):
  - Captures all timing inputs and rgb_in.
  - Captures hit1 = in_win && enable.
  - Captures xoff1 = dx[2:0].
- Stage 2 (registered):
  - Captures the stage-1 timing signals into the *_out ports.
  - rgb_out priority:
    - if hblnk1 || vblnk1: 12'h000
    - else if hit1 && char_pixels[7 - xoff1]: COLOR
    - else: rgb1
- Latency: exactly 2 clocks from any input to the corresponding *_out. char_pixels is sampled during the stage-1 cycle.
- Reset:
  - All stage-1 and stage-2 registers clear to 0.
  - All outputs read 0 in the cycle after rst is sampled high, including hsync_out/vsync_out (sync polarity is handled downstream).
- Reset mid-frame: the pipeline flushes; the first valid output appears 2 cycles after rst is sampled low. No partial state survives.
- enable is sampled per pixel with no hold-off: toggling mid-line takes effect on that pixel's 2-cycle-delayed output.
- Window boundaries:
  - The pixel at XPOS+127 is inside; XPOS+128 is outside.
  - The line at YPOS+255 is inside; YPOS+256 is outside.
  - Parameter sums must not exceed 11 bits; exceeding them is a configuration error.
- Blank overrides glyph: a lit glyph pixel during blank still outputs 12'h000.

Test Plan:
- Reset: hold rst 3 cycles with arbitrary inputs -> every output 0. Release, then drive hcount=10, vcount=10 -> hcount_out=10 and vcount_out=10 exactly 2 cycles later.
- Origin glyph: enable=1, hcount=448, vcount=20, font model returns 8'h80 -> char_xy=8'h00 and char_line=0 same cycle; rgb_out=12'hff0 two cycles later. Next pixel hcount=449 -> rgb_out=rgb_in.
- Addressing: hcount=448+7*8+5=509, vcount=20+16*3+9=77 -> char_xy=8'h37, char_line=9. With char_pixels=8'h04 (bit 2 = 7-5) -> rgb_out=COLOR.
- Boundaries with rgb_in=12'h123 and char_pixels=8'hff:
  - hcount=575 -> COLOR; hcount=576 -> 12'h123 and char_xy=0.
  - vcount=275 -> COLOR; vcount=276 -> 12'h123.
- Blank and enable: inside window with char_pixels=8'hff:
  - hblnk=1 -> rgb_out=0.
  - enable=0 -> rgb_out=rgb_in.
  - Sync/blank pulses appear on the *_out ports delayed exactly 2 cycles.
- Mid-frame reset: stream a full line, assert rst for 1 cycle at hcount=500 -> outputs 0 the next cycle; resumes correct 2-cycle-delayed data with no stale COLOR pixel.
